// File: rtl/scan_chain_ctrl_if.sv
// Tester-side handshake and chain-pin bundle for scan_chain_ctrl.
// The slave modport is the controller; the master modport is the tester plus the chain.
interface scan_chain_ctrl_if #(
   parameter int N = 32
);
   logic         patValid;
   logic         patReady;
   logic [N-1:0] patData;
   logic         flush;
   logic         so;
   logic         se;
   logic         si;
   logic         cke;
   logic         rspValid;
   logic         rspReady;
   logic [N-1:0] rspData;
   logic         busy;

   modport slave (
      input  patValid, patData, flush, so, rspReady,
      output patReady, se, si, cke, rspValid, rspData, busy
   );

   modport master (
      output patValid, patData, flush, so, rspReady,
      input  patReady, se, si, cke, rspValid, rspData, busy
   );
endinterface

// File: rtl/scan_chain_ctrl.sv
// Scan chain controller: shifts a pattern in, runs capture cycles, and shifts the
// previous response out while the next pattern goes in.
module scan_chain_ctrl #(
   parameter int CHAIN_LEN      = 32,
   parameter int CAPTURE_CYCLES = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   scan_chain_ctrl_if.slave  bus
);
   localparam int MAXCNT = (CHAIN_LEN > CAPTURE_CYCLES) ? CHAIN_LEN : CAPTURE_CYCLES;
   localparam int CW     = $clog2(MAXCNT) + 1;

   typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, STALL} state_e;

   state_e                 state_q,    state_d;
   logic [CHAIN_LEN-1:0]   patSr_q,    patSr_d;
   logic [CHAIN_LEN-1:0]   rspSr_q,    rspSr_d;
   logic [CHAIN_LEN-1:0]   rspData_q,  rspData_d;
   logic [CW-1:0]          cnt_q,      cnt_d;
   logic                   unload_q,   unload_d;
   logic                   flushing_q, flushing_d;
   logic                   haveRsp_q,  haveRsp_d;
   logic                   rspValid_q, rspValid_d;

   logic lastShift;
   logic lastCapture;

   assign lastShift   = (cnt_q == CW'(CHAIN_LEN - 1));
   assign lastCapture = (cnt_q == CW'(CAPTURE_CYCLES - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         patSr_q    <= '0;
         rspSr_q    <= '0;
         rspData_q  <= '0;
         cnt_q      <= '0;
         unload_q   <= 1'b0;
         flushing_q <= 1'b0;
         haveRsp_q  <= 1'b0;
         rspValid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         patSr_q    <= patSr_d;
         rspSr_q    <= rspSr_d;
         rspData_q  <= rspData_d;
         cnt_q      <= cnt_d;
         unload_q   <= unload_d;
         flushing_q <= flushing_d;
         haveRsp_q  <= haveRsp_d;
         rspValid_q <= rspValid_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      patSr_d    = patSr_q;
      rspSr_d    = rspSr_q;
      rspData_d  = rspData_q;
      cnt_d      = cnt_q;
      unload_d   = unload_q;
      flushing_d = flushing_q;
      haveRsp_d  = haveRsp_q;
      rspValid_d = rspValid_q;

      if (rspValid_q && bus.rspReady) begin
         rspValid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (bus.patValid) begin
               patSr_d    = bus.patData;
               unload_d   = haveRsp_q;
               flushing_d = 1'b0;
               cnt_d      = '0;
               state_d    = SHIFT;
            end else if (bus.flush && haveRsp_q) begin
               patSr_d    = '0;
               unload_d   = 1'b1;
               flushing_d = 1'b1;
               cnt_d      = '0;
               state_d    = SHIFT;
            end
         end

         SHIFT: begin
            patSr_d = {patSr_q[CHAIN_LEN-2:0], 1'b0};
            rspSr_d = {rspSr_q[CHAIN_LEN-2:0], bus.so};
            cnt_d   = cnt_q + CW'(1);
            if (lastShift) begin
               cnt_d = '0;
               if (!unload_q) begin
                  state_d = CAPTURE;
               end else if (!rspValid_q || bus.rspReady) begin
                  // The final SO bit arrives this edge, so hand over the shifted-in view.
                  rspData_d  = {rspSr_q[CHAIN_LEN-2:0], bus.so};
                  rspValid_d = 1'b1;
                  if (flushing_q) begin
                     state_d   = IDLE;
                     haveRsp_d = 1'b0;
                  end else begin
                     state_d = CAPTURE;
                  end
               end else begin
                  state_d = STALL;
               end
            end
         end

         STALL: begin
            if (bus.rspReady) begin
               rspData_d  = rspSr_q;
               rspValid_d = 1'b1;
               cnt_d      = '0;
               if (flushing_q) begin
                  state_d   = IDLE;
                  haveRsp_d = 1'b0;
               end else begin
                  state_d = CAPTURE;
               end
            end
         end

         CAPTURE: begin
            cnt_d = cnt_q + CW'(1);
            if (lastCapture) begin
               cnt_d     = '0;
               haveRsp_d = 1'b1;
               if (bus.patValid) begin
                  patSr_d    = bus.patData;
                  unload_d   = 1'b1;
                  flushing_d = 1'b0;
                  state_d    = SHIFT;
               end else begin
                  state_d = IDLE;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // Every output is a decode of registered state; nothing passes straight from an input.
   always_comb begin
      bus.patReady = (state_q == IDLE) || ((state_q == CAPTURE) && lastCapture);
      bus.se       = (state_q == SHIFT);
      bus.cke      = (state_q == SHIFT) || (state_q == CAPTURE);
      bus.si       = (state_q == SHIFT) ? patSr_q[CHAIN_LEN-1] : 1'b0;
      bus.rspValid = rspValid_q;
      bus.rspData  = rspData_q;
      bus.busy     = (state_q != IDLE);
   end
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl with an 8-cell inverting scan chain model and a response scoreboard.
module tb_scan_chain_ctrl;
   localparam int N = 8;

   logic clk = 1'b0;
   logic rst;
   int   errorCount = 0;
   int   checkCount = 0;

   logic [N-1:0] sbQ[$];
   logic [N-1:0] chainQ = '0;

   scan_chain_ctrl_if #(.N(N)) dutIf ();

   scan_chain_ctrl #(.CHAIN_LEN(N), .CAPTURE_CYCLES(1)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (dutIf)
   );

   always #5 clk = ~clk;

   // Chain of sdffq cells: shift when SE=1, capture D=~Q when SE=0, frozen when CKE=0.
   always @(posedge clk) begin
      if (dutIf.cke) chainQ <= dutIf.se ? {chainQ[N-2:0], dutIf.si} : ~chainQ;
   end
   assign dutIf.so = chainQ[N-1];

   // Scoreboard: each accepted response handshake must match the oldest expected capture.
   always @(negedge clk) begin
      #2;
      if (!rst && dutIf.rspValid && dutIf.rspReady) begin
         checkCount++;
         if (sbQ.size() == 0) begin
            errorCount++;
            $display("[TB] FAIL rsp_unexpected: got %h expected none", dutIf.rspData);
         end else begin
            logic [N-1:0] exp;
            exp = sbQ.pop_front();
            if (dutIf.rspData !== exp) begin
               errorCount++;
               $display("[TB] FAIL rsp_data: got %h expected %h", dutIf.rspData, exp);
            end
         end
      end
   end

   task automatic sendPattern(input logic [N-1:0] pat);
      int guard = 0;
      dutIf.patValid = 1'b1;
      dutIf.patData  = pat;
      while (!dutIf.patReady && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) begin
         checkCount++;
         errorCount++;
         $display("[TB] FAIL pat_accept_timeout: got ready=0 expected ready=1");
      end else begin
         sbQ.push_back(~pat);
      end
      @(negedge clk);
      dutIf.patValid = 1'b0;
   endtask

   task automatic waitIdle();
      int guard = 0;
      while (dutIf.busy && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) begin
         checkCount++;
         errorCount++;
         $display("[TB] FAIL idle_timeout: got busy=1 expected busy=0");
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      checkCount++;
      if ({dutIf.se, dutIf.si, dutIf.cke, dutIf.rspValid, dutIf.busy, dutIf.patReady} !== 6'b000001) begin
         errorCount++;
         $display("[TB] FAIL reset_outputs: got %b expected 000001",
                  {dutIf.se, dutIf.si, dutIf.cke, dutIf.rspValid, dutIf.busy, dutIf.patReady});
      end
      checkCount++;
      if (dutIf.rspData !== '0) begin
         errorCount++;
         $display("[TB] FAIL reset_rspdata: got %h expected 00", dutIf.rspData);
      end
   endtask

   task automatic test_shift_load();
      logic [N-1:0] pat;
      pat = 8'hA5;
      sendPattern(pat);
      for (int i = 0; i < N; i++) begin
         checkCount++;
         if ({dutIf.se, dutIf.cke, dutIf.si} !== {2'b11, pat[N-1-i]}) begin
            errorCount++;
            $display("[TB] FAIL shift_bit%0d: got se/cke/si=%b expected %b", i,
                     {dutIf.se, dutIf.cke, dutIf.si}, {2'b11, pat[N-1-i]});
         end
         @(negedge clk);
      end
      checkCount++;
      if ({dutIf.se, dutIf.cke} !== 2'b01 || chainQ !== 8'hA5) begin
         errorCount++;
         $display("[TB] FAIL capture_chain: got se/cke=%b chain=%h expected 01 a5",
                  {dutIf.se, dutIf.cke}, chainQ);
      end
      waitIdle();
   endtask

   task automatic test_back_to_back();
      int cnt = 1;
      sendPattern(8'hA5);
      sendPattern(8'h3C);
      while (!dutIf.rspValid && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      checkCount++;
      if (cnt != 9) begin
         errorCount++;
         $display("[TB] FAIL rsp_latency: got %0d expected 9", cnt);
      end
      checkCount++;
      if (dutIf.rspData !== 8'h5A) begin
         errorCount++;
         $display("[TB] FAIL b2b_rsp: got %h expected 5a", dutIf.rspData);
      end
      waitIdle();
   endtask

   task automatic test_stall();
      dutIf.rspReady = 1'b0;
      sendPattern(8'h96);
      sendPattern(8'h0F);
      repeat (N) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         checkCount++;
         if ({dutIf.se, dutIf.cke, dutIf.busy, dutIf.rspValid, dutIf.patReady} !== 5'b00110) begin
            errorCount++;
            $display("[TB] FAIL stall_ctrl%0d: got %b expected 00110", i,
                     {dutIf.se, dutIf.cke, dutIf.busy, dutIf.rspValid, dutIf.patReady});
         end
         checkCount++;
         if (dutIf.rspData !== 8'hC3 || chainQ !== 8'h0F) begin
            errorCount++;
            $display("[TB] FAIL stall_hold%0d: got rsp=%h chain=%h expected c3 0f", i,
                     dutIf.rspData, chainQ);
         end
         @(negedge clk);
      end
      dutIf.rspReady = 1'b1;
      @(negedge clk);
      checkCount++;
      if (dutIf.rspValid !== 1'b1 || dutIf.rspData !== 8'h69) begin
         errorCount++;
         $display("[TB] FAIL stall_release: got valid=%b rsp=%h expected 1 69",
                  dutIf.rspValid, dutIf.rspData);
      end
      waitIdle();
   endtask

   task automatic test_flush();
      dutIf.flush = 1'b1;
      @(negedge clk);
      dutIf.flush = 1'b0;
      for (int i = 0; i < N; i++) begin
         checkCount++;
         if ({dutIf.se, dutIf.si} !== 2'b10) begin
            errorCount++;
            $display("[TB] FAIL flush_shift%0d: got se/si=%b expected 10", i, {dutIf.se, dutIf.si});
         end
         @(negedge clk);
      end
      checkCount++;
      if ({dutIf.busy, dutIf.rspValid} !== 2'b01 || dutIf.rspData !== 8'hF0 || chainQ !== 8'h00) begin
         errorCount++;
         $display("[TB] FAIL flush_done: got busy/valid=%b rsp=%h chain=%h expected 01 f0 00",
                  {dutIf.busy, dutIf.rspValid}, dutIf.rspData, chainQ);
      end
      dutIf.flush = 1'b1;
      @(negedge clk);
      dutIf.flush = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checkCount++;
         if ({dutIf.busy, dutIf.rspValid, dutIf.cke} !== 3'b000) begin
            errorCount++;
            $display("[TB] FAIL flush_ignored%0d: got %b expected 000", i,
                     {dutIf.busy, dutIf.rspValid, dutIf.cke});
         end
         @(negedge clk);
      end
   endtask

   task automatic test_mid_reset();
      sendPattern(8'h81);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkCount++;
      if ({dutIf.se, dutIf.si, dutIf.cke, dutIf.rspValid, dutIf.busy, dutIf.patReady} !== 6'b000001
          || dutIf.rspData !== '0) begin
         errorCount++;
         $display("[TB] FAIL mid_reset: got %b rsp=%h expected 000001 00",
                  {dutIf.se, dutIf.si, dutIf.cke, dutIf.rspValid, dutIf.busy, dutIf.patReady},
                  dutIf.rspData);
      end
      rst = 1'b0;
      sbQ.delete();
      sendPattern(8'h5C);
      waitIdle();
      checkCount++;
      if (chainQ !== 8'hA3) begin
         errorCount++;
         $display("[TB] FAIL reload_capture: got %h expected a3", chainQ);
      end
      dutIf.flush = 1'b1;
      @(negedge clk);
      dutIf.flush = 1'b0;
      waitIdle();
      repeat (2) @(negedge clk);
      checkCount++;
      if (sbQ.size() != 0) begin
         errorCount++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sbQ.size());
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst            = 1'b1;
      dutIf.patValid = 1'b0;
      dutIf.patData  = '0;
      dutIf.flush    = 1'b0;
      dutIf.rspReady = 1'b1;
      test_reset();
      test_shift_load();
      test_back_to_back();
      test_stall();
      test_flush();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end
endmodule
